// File: rtl/icache_refill_bridge.sv
// Bridges I-cache line refill requests onto a single AXI INCR burst of LINE_WORDS 32-bit beats.
// Latency: accept at cycle 0, AR at 1, beats from 2, line valid one cycle after the final beat.
// Backpressure: one transaction in flight; AR/R/line handshakes stall the FSM, requests while busy are dropped.
module icache_refill_bridge #(
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_ren_i,
    input  logic                     mem_arvalid_i,
    input  logic [31:0]              mem_araddr_i,
    output logic                     mem_arready_o,
    output logic                     mem_rvalid_o,
    input  logic                     mem_rready_i,
    output logic [LINE_WORDS*32-1:0] mem_rdata_o,
    output logic                     mem_rerr_o,
    output logic [31:0]              axi_araddr_o,
    output logic [7:0]               axi_arlen_o,
    output logic [2:0]               axi_arsize_o,
    output logic [1:0]               axi_arburst_o,
    output logic                     axi_arvalid_o,
    input  logic                     axi_arready_i,
    input  logic [31:0]              axi_rdata_i,
    input  logic [1:0]               axi_rresp_i,
    input  logic                     axi_rlast_i,
    input  logic                     axi_rvalid_i,
    output logic                     axi_rready_o
);

    localparam int              CW       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int              LW       = LINE_WORDS * 32;
    localparam logic [31:0]     OFF_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // buf_q accumulates beats; line_q is the delivered line, so the last line
    // stays visible on mem_rdata_o while the next refill is being collected.
    logic [LW-1:0]   buf_q, buf_d;
    logic [LW-1:0]   line_q, line_d;
    logic            err_q, err_d;

    assign mem_rdata_o = line_q;

    // Next-state, datapath updates and all handshake outputs decoded from the current state.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        line_d        = line_q;
        err_d         = err_q;
        mem_arready_o = 1'b0;
        mem_rvalid_o  = 1'b0;
        mem_rerr_o    = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_araddr_o  = '0;
        axi_arlen_o   = '0;
        axi_arsize_o  = '0;
        axi_arburst_o = '0;
        axi_rready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so the ready flag is low while reset is held.
                mem_arready_o = rst;
                if (mem_arvalid_i && mem_ren_i) begin
                    addr_d  = mem_araddr_i & ~OFF_MASK;
                    cnt_d   = '0;
                    buf_d   = '0;
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                axi_arvalid_o = 1'b1;
                axi_araddr_o  = addr_q;
                axi_arlen_o   = 8'(LINE_WORDS - 1);
                axi_arsize_o  = 3'b010;
                axi_arburst_o = 2'b01;
                if (axi_arready_i) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                axi_rready_o = 1'b1;
                if (axi_rvalid_i) begin
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            buf_d[k*32 +: 32] = axi_rdata_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (axi_rresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        // Full line received; a missing rlast marks a protocol error.
                        state_d = RESP;
                        line_d  = buf_d;
                        if (!axi_rlast_i) begin
                            err_d = 1'b1;
                        end
                    end else if (axi_rlast_i) begin
                        // Short burst: unfilled words stay zero and the line is flagged.
                        state_d = RESP;
                        line_d  = buf_d;
                        err_d   = 1'b1;
                    end
                end
            end

            RESP: begin
                mem_rvalid_o = 1'b1;
                mem_rerr_o   = err_q;
                if (mem_rready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge: table of refill transactions plus reset/ignore sequences.
// Each vector carries its own AR/R/line stall pattern and hand-computed line, error and latency.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_icache_refill_bridge;

    logic         clk;
    logic         rst;
    logic         mem_ren_i;
    logic         mem_arvalid_i;
    logic [31:0]  mem_araddr_i;
    logic         mem_arready_o;
    logic         mem_rvalid_o;
    logic         mem_rready_i;
    logic [255:0] mem_rdata_o;
    logic         mem_rerr_o;
    logic [31:0]  axi_araddr_o;
    logic [7:0]   axi_arlen_o;
    logic [2:0]   axi_arsize_o;
    logic [1:0]   axi_arburst_o;
    logic         axi_arvalid_o;
    logic         axi_arready_i;
    logic [31:0]  axi_rdata_i;
    logic [1:0]   axi_rresp_i;
    logic         axi_rlast_i;
    logic         axi_rvalid_i;
    logic         axi_rready_o;

    int checks   = 0;
    int failures = 0;

    icache_refill_bridge #(.LINE_WORDS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ren_i     (mem_ren_i),
        .mem_arvalid_i (mem_arvalid_i),
        .mem_araddr_i  (mem_araddr_i),
        .mem_arready_o (mem_arready_o),
        .mem_rvalid_o  (mem_rvalid_o),
        .mem_rready_i  (mem_rready_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_rerr_o    (mem_rerr_o),
        .axi_araddr_o  (axi_araddr_o),
        .axi_arlen_o   (axi_arlen_o),
        .axi_arsize_o  (axi_arsize_o),
        .axi_arburst_o (axi_arburst_o),
        .axi_arvalid_o (axi_arvalid_o),
        .axi_arready_i (axi_arready_i),
        .axi_rdata_i   (axi_rdata_i),
        .axi_rresp_i   (axi_rresp_i),
        .axi_rlast_i   (axi_rlast_i),
        .axi_rvalid_i  (axi_rvalid_i),
        .axi_rready_o  (axi_rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        int           dsel;       // data set: 0 = reference words, 1 = A500000k
        int           ard;        // cycles axi_arready_i is held low in ADDR
        int           gap;        // idle cycles between beats
        int           rd;         // cycles mem_rready_i is held low in RESP
        int           err_beat;   // beat index carrying SLVERR (8 = none)
        int           last_beat;  // beat index carrying rlast (15 = never)
        bit           busy_req;   // keep a competing request high while busy
        bit           junk;       // drive rvalid outside DATA
        logic [31:0]  exp_araddr;
        logic [255:0] exp_line;
        bit           exp_err;
        int           exp_lat;    // cycle index of first mem_rvalid_o
    } vec_t;

    logic [31:0] wds [2][8];
    vec_t        vecs [8];

    localparam logic [255:0] L0 = 256'h12345678_91023456_78910234_56789102_34567891_02345678_91023456_78910234;
    localparam logic [255:0] L1 = 256'hA5000007_A5000006_A5000005_A5000004_A5000003_A5000002_A5000001_A5000000;
    localparam logic [255:0] LE = 256'h00000000_00000000_00000000_56789102_34567891_02345678_91023456_78910234;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ren_i     = 1'b0;
        mem_arvalid_i = 1'b0;
        mem_araddr_i  = '0;
        mem_rready_i  = 1'b0;
        axi_arready_i = 1'b0;
        axi_rdata_i   = '0;
        axi_rresp_i   = '0;
        axi_rlast_i   = 1'b0;
        axi_rvalid_i  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        int b;
        int gap;
        int guard;
        bit done;
        // cycle 0: present the request
        mem_arvalid_i = 1'b1;
        mem_ren_i     = 1'b1;
        mem_araddr_i  = v.addr;
        chk($sformatf("v%0d_arready_idle", id), 256'(mem_arready_o), 256'(1));
        step();
        cyc = 1;
        mem_arvalid_i = v.busy_req;
        mem_araddr_i  = 32'hFFFF_FFE0;
        // ADDR phase, AR fields must stay stable while stalled
        for (int i = 0; i <= v.ard; i++) begin
            chk($sformatf("v%0d_arvalid", id), 256'(axi_arvalid_o), 256'(1));
            chk($sformatf("v%0d_araddr", id), 256'(axi_araddr_o), 256'(v.exp_araddr));
            chk($sformatf("v%0d_arctl", id), 256'({axi_arlen_o, axi_arsize_o, axi_arburst_o}),
                256'({8'd7, 3'b010, 2'b01}));
            chk($sformatf("v%0d_arready_busy", id), 256'(mem_arready_o), 256'(0));
            axi_arready_i = (i == v.ard);
            axi_rvalid_i  = v.junk;
            axi_rdata_i   = 32'hBAD0_BAD0;
            axi_rresp_i   = 2'b11;
            axi_rlast_i   = v.junk;
            step();
            cyc++;
        end
        axi_arready_i = 1'b0;
        // DATA phase
        b = 0; gap = 0; done = 1'b0; guard = 0;
        while (!done && guard < 200) begin
            if (b == 0 && gap == 0)
                chk($sformatf("v%0d_rready_data", id), 256'(axi_rready_o), 256'(1));
            if (gap == 0) begin
                axi_rvalid_i = 1'b1;
                axi_rdata_i  = wds[v.dsel][b];
                axi_rresp_i  = (b == v.err_beat) ? 2'b10 : 2'b00;
                axi_rlast_i  = (b == v.last_beat);
            end else begin
                axi_rvalid_i = 1'b0;
                axi_rdata_i  = 32'hDEAD_DEAD;
                axi_rlast_i  = 1'b1;
            end
            step();
            cyc++;
            guard++;
            if (gap == 0) begin
                b++;
                gap = v.gap;
                if (b == 8 || b - 1 == v.last_beat) done = 1'b1;
            end else begin
                gap--;
            end
        end
        if (!done) chk($sformatf("v%0d_data_timeout", id), 256'(guard), 256'(0));
        axi_rvalid_i = 1'b0;
        axi_rlast_i  = 1'b0;
        axi_rresp_i  = 2'b00;
        chk($sformatf("v%0d_latency", id), 256'(mem_rvalid_o ? cyc : -1), 256'(v.exp_lat));
        chk($sformatf("v%0d_rready_resp", id), 256'(axi_rready_o), 256'(0));
        // RESP phase, line held until accepted
        for (int i = 0; i <= v.rd; i++) begin
            chk($sformatf("v%0d_rvalid", id), 256'(mem_rvalid_o), 256'(1));
            chk($sformatf("v%0d_line", id), mem_rdata_o, v.exp_line);
            chk($sformatf("v%0d_rerr", id), 256'(mem_rerr_o), 256'(v.exp_err));
            mem_rready_i = (i == v.rd);
            axi_rvalid_i = v.junk;
            axi_rdata_i  = 32'hBAD1_BAD1;
            step();
        end
        mem_rready_i  = 1'b0;
        axi_rvalid_i  = 1'b0;
        mem_arvalid_i = 1'b0;
        chk($sformatf("v%0d_rvalid_drop", id), 256'(mem_rvalid_o), 256'(0));
        chk($sformatf("v%0d_arready_back", id), 256'(mem_arready_o), 256'(1));
        chk($sformatf("v%0d_line_hold", id), mem_rdata_o, v.exp_line);
        step();
        chk($sformatf("v%0d_no_extra_accept", id), 256'({axi_arvalid_o, mem_arready_o}), 256'(2'b01));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) wds[1][k] = 32'hA500_0000 + 32'(k);
        wds[0][0] = 32'h78910234; wds[0][1] = 32'h91023456;
        wds[0][2] = 32'h02345678; wds[0][3] = 32'h34567891;
        wds[0][4] = 32'h56789102; wds[0][5] = 32'h78910234;
        wds[0][6] = 32'h91023456; wds[0][7] = 32'h12345678;
        //          addr          dsel ard gap rd errb lastb busy junk exp_araddr    line err lat
        vecs[0] = '{32'hDEBAD000, 0, 0, 0, 0, 8, 7,  0, 0, 32'hDEBAD000, L0, 0, 10};
        vecs[1] = '{32'h24687574, 0, 0, 0, 0, 8, 7,  0, 0, 32'h24687560, L0, 0, 10};
        vecs[2] = '{32'hDEBAD000, 0, 3, 2, 4, 8, 7,  1, 1, 32'hDEBAD000, L0, 0, 27};
        vecs[3] = '{32'h0000101C, 0, 0, 0, 0, 2, 7,  0, 0, 32'h00001000, L0, 1, 10};
        vecs[4] = '{32'h00001020, 1, 0, 0, 0, 8, 7,  0, 0, 32'h00001020, L1, 0, 10};
        vecs[5] = '{32'h80000044, 0, 0, 0, 0, 8, 4,  0, 0, 32'h80000040, LE, 1, 7};
        vecs[6] = '{32'h7FFFFFFF, 1, 0, 0, 0, 8, 15, 0, 0, 32'h7FFFFFE0, L1, 1, 10};
        vecs[7] = '{32'h12345678, 1, 1, 1, 2, 8, 7,  1, 1, 32'h12345660, L1, 0, 18};

        // reset state
        #1;
        chk("rst_arready", 256'(mem_arready_o), 256'(0));
        chk("rst_outputs", 256'({mem_rvalid_o, mem_rerr_o, axi_arvalid_o, axi_rready_o,
                                 axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o}), 256'(0));
        chk("rst_rdata", mem_rdata_o, 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_arready", 256'(mem_arready_o), 256'(1));

        // request without read enable is not accepted
        mem_arvalid_i = 1'b1;
        mem_araddr_i  = 32'hDEBAD000;
        step();
        step();
        chk("no_ren_ignored", 256'({axi_arvalid_o, mem_arready_o}), 256'(2'b01));
        mem_arvalid_i = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset in the middle of beat 4 abandons the burst
        mem_arvalid_i = 1'b1;
        mem_ren_i     = 1'b1;
        mem_araddr_i  = 32'hDEBAD000;
        step();
        mem_arvalid_i = 1'b0;
        axi_arready_i = 1'b1;
        step();
        axi_arready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = wds[0][b];
            step();
        end
        axi_rdata_i = wds[0][3];
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_outputs", 256'({mem_arready_o, mem_rvalid_o, mem_rerr_o, axi_arvalid_o, axi_rready_o}), 256'(0));
        chk("midrst_rdata", mem_rdata_o, 256'(0));
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("midrst_arready", 256'(mem_arready_o), 256'(1));
        for (int i = 0; i < 12; i++) begin
            if (mem_rvalid_o !== 1'b0 || axi_arvalid_o !== 1'b0)
                chk("midrst_no_delivery", 256'({mem_rvalid_o, axi_arvalid_o}), 256'(0));
            step();
        end
        chk("midrst_quiet", 256'({mem_rvalid_o, axi_arvalid_o, axi_rready_o, mem_arready_o}), 256'(1));
        run_vec(vecs[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_refill_bridge.md
ICACHE_REFILL_BRIDGE -- requirements
Module: icache_refill_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per cache line (32-bit words; line 256 bits).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port mem_ren_i  input  1  cache read enable.
REQ-005 SHALL have port mem_arvalid_i  input  1  cache line-request valid.
REQ-006 SHALL have port mem_araddr_i  input  32  line request address (any byte offset).
REQ-007 SHALL have port mem_arready_o  output  1  bridge can accept a request.
REQ-008 SHALL have port mem_rvalid_o  output  1  refilled line valid.
REQ-009 SHALL have port mem_rready_i  input  1  cache accepts line.
REQ-010 SHALL have port mem_rdata_o  output  256  refilled line; word k at bits [32k+31:32k].
REQ-011 SHALL have port mem_rerr_o  output  1  line carries bus error; valid only with mem_rvalid_o.
REQ-012 SHALL have ports axi_araddr_o out 32, axi_arlen_o out 8, axi_arsize_o out 3, axi_arburst_o out 2, axi_arvalid_o out 1, axi_arready_i in 1: AXI read-address channel.
REQ-013 SHALL have ports axi_rdata_i in 32, axi_rresp_i in 2, axi_rlast_i in 1, axi_rvalid_i in 1, axi_rready_o out 1: AXI read-data channel.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, RESP; reset state IDLE.
REQ-015 IDLE: mem_arready_o=1; on mem_arvalid_i&mem_ren_i latch {mem_araddr_i[31:5],5'b0}, clear word counter, buffer and error flag, go ADDR next cycle.
REQ-016 mem_arready_o SHALL be 0 in ADDR, DATA, RESP; requests arriving then are ignored (not queued).
REQ-017 ADDR: axi_arvalid_o=1, axi_araddr_o=latched aligned address, axi_arlen_o=LINE_WORDS-1 (8'd7), axi_arsize_o=3'b010, axi_arburst_o=2'b01 (INCR); these held stable until axi_arready_i, then go DATA.
REQ-018 axi_arvalid_o SHALL be 0 outside ADDR; axi_araddr_o value outside ADDR is don't-care.
REQ-019 DATA: axi_rready_o=1; each cycle with axi_rvalid_i stores axi_rdata_i into word[cnt], cnt increments (3-bit, no wrap used).
REQ-020 Beat with axi_rresp_i!=2'b00 SHALL set sticky error flag; data still stored.
REQ-021 Beat with axi_rlast_i=1 before the 8th beat SHALL end the burst: error flag set, unfilled words remain 0, go RESP.
REQ-022 8th beat SHALL go RESP regardless of axi_rlast_i; if axi_rlast_i=0 on it, error flag set; axi_rready_o=0 from the next cycle.
REQ-023 RESP: mem_rvalid_o=1, mem_rdata_o=buffer, mem_rerr_o=error flag, all held stable until mem_rready_i; on mem_rvalid_o&mem_rready_i go IDLE next cycle.
REQ-024 mem_rvalid_o SHALL be 0 outside RESP; mem_rdata_o SHALL hold last line outside RESP.
REQ-025 Minimum latency, axi_arready_i and axi_rvalid_i always high, mem_rready_i high: request accepted cycle 0, axi_arvalid_o cycle 1, beats cycles 2-9, mem_rvalid_o cycle 10, mem_arready_o again cycle 11.
REQ-026 axi_rvalid_i outside DATA SHALL be ignored (axi_rready_o=0).

Reset
REQ-027 On rst=0 all outputs SHALL go 0 asynchronously except mem_arready_o (0 during reset, 1 first cycle after release); state IDLE, buffer, counter, error flag cleared.
REQ-028 Reset asserted mid-burst SHALL abandon the transaction; no line or error is delivered after release.

Verification
REQ-029 Request 0xDEBAD000, slave returns words 0x78910234,0x91023456,0x02345678,0x34567891,0x56789102,0x78910234,0x91023456,0x12345678 with rlast on 8th -> axi_araddr_o=0xDEBAD000, arlen=7; mem_rdata_o=256'h12345678_91023456_78910234_56789102_34567891_02345678_91023456_78910234, mem_rerr_o=0, mem_rvalid_o at cycle 10.
REQ-030 Request 0x24687574 -> axi_araddr_o=0x24687560; same data; bits[159:128]=0x56789102.
REQ-031 axi_arready_i delayed 3 cycles, rvalid gaps of 2 cycles between beats, mem_rready_i delayed 4 cycles -> address/data held stable, line identical to REQ-029, exactly one acceptance.
REQ-032 Beat 3 rresp=2'b10 -> mem_rerr_o=1 with line; next clean request -> mem_rerr_o=0.
REQ-033 rlast on beat 5 -> RESP after beat 5, words 5-7 zero, mem_rerr_o=1.
REQ-034 rst=0 during beat 4 -> outputs 0 immediately; after release mem_arready_o=1, no mem_rvalid_o until a new request completes.
